// File: rtl/cache_pkg.sv
// Shared types and address-field helpers for the L1 data cache.
//   cache_state_t : controller state encoding
//   BE_WORD       : byte-enable pattern for a full-word access
//   ADDR_W/OFF_W  : byte-address width and in-word offset width
//   tag_width()   : tag bits left after offset and index are removed
package cache_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        RD_MISS = 2'b01,
        WR_THRU = 2'b10,
        DONE    = 2'b11
    } cache_state_t;

    localparam logic [3:0] BE_WORD    = 4'b1111;
    localparam int unsigned ADDR_W     = 32;
    localparam int unsigned OFF_W      = 2;
    localparam int unsigned WORD_BYTES = 4;

    function automatic int unsigned tag_width(input int unsigned sets);
        return ADDR_W - OFF_W - $clog2(sets);
    endfunction

endpackage

// File: rtl/cache_line_array.sv
// Valid/tag/data storage for a direct-mapped cache of one-word lines.
//   clk, rst       : clock, synchronous active-low reset (clears valid bits only)
//   rd_idx         : lookup index; rd_valid/rd_tag/rd_data are combinational
//   wr_en          : write strobe for the line at wr_idx
//   wr_alloc       : with wr_en, also write wr_tag and set the valid bit (fill)
//   wr_be/wr_data  : byte enables and data for the line update
module cache_line_array
    import cache_pkg::*;
#(
    parameter int unsigned SETS  = 16,
    parameter int unsigned TAG_W = 26
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [$clog2(SETS)-1:0] rd_idx,
    output logic                    rd_valid,
    output logic [TAG_W-1:0]        rd_tag,
    output logic [31:0]             rd_data,
    input  logic                    wr_en,
    input  logic                    wr_alloc,
    input  logic [$clog2(SETS)-1:0] wr_idx,
    input  logic [3:0]              wr_be,
    input  logic [TAG_W-1:0]        wr_tag,
    input  logic [31:0]             wr_data
);

    logic [SETS-1:0]  valid_q;
    logic [TAG_W-1:0] tag_q  [SETS];
    logic [31:0]      data_q [SETS];

    assign rd_valid = valid_q[rd_idx];
    assign rd_tag   = tag_q[rd_idx];
    assign rd_data  = data_q[rd_idx];

    always_ff @(posedge clk) begin
        if (!rst) begin
            valid_q <= '0;
        end else if (wr_en && wr_alloc) begin
            valid_q[wr_idx] <= 1'b1;
        end
    end

    // Tag and data need no reset: nothing is read as a hit until valid is set.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            if (wr_alloc) begin
                tag_q[wr_idx] <= wr_tag;
            end
            for (int b = 0; b < WORD_BYTES; b++) begin
                if (wr_be[b]) begin
                    data_q[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
                end
            end
        end
    end

endmodule

// File: rtl/data_cache.sv
// Direct-mapped, write-through L1 data cache with no write-allocate.
//   clk, rst                 : clock, synchronous active-low reset
//   MemReadM/MemWriteM       : load/store in M stage (store wins if both)
//   LdSrcM/StSrcM            : 1 = byte access (lbu / sb), 0 = word
//   ALUResultM/WriteDataM    : byte address and store data
//   ReadDataM/StallM         : load result and pipeline stall
//   mem_req/mem_we/mem_addr/mem_wdata/mem_be : registered backing-memory request
//   mem_rdata/mem_ack        : fill data and one-cycle completion pulse
//   hit_count/miss_count     : saturating load hit/miss counters
module data_cache
    import cache_pkg::*;
#(
    parameter int unsigned SETS      = 16,
    parameter int unsigned CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 MemReadM,
    input  logic                 MemWriteM,
    input  logic                 LdSrcM,
    input  logic                 StSrcM,
    input  logic [31:0]          ALUResultM,
    input  logic [31:0]          WriteDataM,
    output logic [31:0]          ReadDataM,
    output logic                 StallM,
    output logic                 mem_req,
    output logic                 mem_we,
    output logic [31:0]          mem_addr,
    output logic [31:0]          mem_wdata,
    output logic [3:0]           mem_be,
    input  logic [31:0]          mem_rdata,
    input  logic                 mem_ack,
    output logic [CNT_WIDTH-1:0] hit_count,
    output logic [CNT_WIDTH-1:0] miss_count
);

    localparam int unsigned IDX_W = $clog2(SETS);
    localparam int unsigned TAG_W = tag_width(SETS);

    cache_state_t state_q, state_d;

    logic [IDX_W-1:0] idx;
    logic [TAG_W-1:0] tag;
    logic             rd_valid;
    logic [TAG_W-1:0] rd_tag;
    logic [31:0]      rd_data;
    logic             hit;
    logic             is_store;
    logic             is_load;
    logic             capture;
    logic             st_hit_q;
    logic [31:0]      st_wdata;
    logic [3:0]       st_be;
    logic             fill_en;
    logic             upd_en;

    assign idx      = ALUResultM[IDX_W+OFF_W-1:OFF_W];
    assign tag      = ALUResultM[ADDR_W-1:IDX_W+OFF_W];
    assign hit      = rd_valid && (rd_tag == tag);
    assign is_store = MemWriteM;
    assign is_load  = MemReadM && !MemWriteM;
    assign capture  = (state_q == IDLE) && (is_store || (is_load && !hit));

    // Byte store: data and enable moved into the addressed lane.
    assign st_wdata = StSrcM ? (32'(WriteDataM[7:0]) << {ALUResultM[1:0], 3'b000}) : WriteDataM;
    assign st_be    = StSrcM ? (4'b0001 << ALUResultM[1:0]) : BE_WORD;

    // Line writes are gated by rst so an ack landing on a reset edge is dropped.
    assign fill_en = rst && (state_q == RD_MISS) && mem_ack;
    assign upd_en  = rst && (state_q == WR_THRU) && mem_ack && st_hit_q;

    cache_line_array #(
        .SETS  (SETS),
        .TAG_W (TAG_W)
    ) u_lines (
        .clk      (clk),
        .rst      (rst),
        .rd_idx   (idx),
        .rd_valid (rd_valid),
        .rd_tag   (rd_tag),
        .rd_data  (rd_data),
        .wr_en    (fill_en || upd_en),
        .wr_alloc (fill_en),
        .wr_idx   (mem_addr[IDX_W+OFF_W-1:OFF_W]),
        .wr_be    (fill_en ? BE_WORD : mem_be),
        .wr_tag   (mem_addr[ADDR_W-1:IDX_W+OFF_W]),
        .wr_data  (fill_en ? mem_rdata : mem_wdata)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (is_store) begin
                    state_d = WR_THRU;
                end else if (is_load && !hit) begin
                    state_d = RD_MISS;
                end
            end
            RD_MISS: if (mem_ack) state_d = DONE;
            WR_THRU: if (mem_ack) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= IDLE;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            mem_be     <= '0;
            st_hit_q   <= 1'b0;
            hit_count  <= '0;
            miss_count <= '0;
        end else begin
            state_q <= state_d;
            if (capture) begin
                mem_req   <= 1'b1;
                mem_we    <= is_store;
                mem_addr  <= {ALUResultM[31:2], 2'b00};
                mem_wdata <= is_store ? st_wdata : '0;
                mem_be    <= is_store ? st_be : BE_WORD;
                st_hit_q  <= hit;
            end else if (mem_ack && (state_q == RD_MISS || state_q == WR_THRU)) begin
                mem_req <= 1'b0;
            end
            if (state_q == IDLE && is_load && hit && !(&hit_count)) begin
                hit_count <= hit_count + CNT_WIDTH'(1);
            end
            if (capture && is_load && !(&miss_count)) begin
                miss_count <= miss_count + CNT_WIDTH'(1);
            end
        end
    end

    always_comb begin
        ReadDataM = '0;
        if (is_load) begin
            if (LdSrcM) begin
                unique case (ALUResultM[1:0])
                    2'd0: ReadDataM = {24'b0, rd_data[7:0]};
                    2'd1: ReadDataM = {24'b0, rd_data[15:8]};
                    2'd2: ReadDataM = {24'b0, rd_data[23:16]};
                    2'd3: ReadDataM = {24'b0, rd_data[31:24]};
                    default: ReadDataM = '0;
                endcase
            end else begin
                ReadDataM = rd_data;
            end
        end
    end

    assign StallM = rst && ((state_q == RD_MISS) || (state_q == WR_THRU) ||
                            ((state_q == IDLE) && (MemWriteM || (MemReadM && !hit))));

endmodule

// File: tb/tb_data_cache.sv
module tb_data_cache;

    logic        clk = 1'b0;
    logic        rst;
    logic        MemReadM, MemWriteM, LdSrcM, StSrcM;
    logic [31:0] ALUResultM, WriteDataM;
    logic [31:0] ReadDataM, s_ReadDataM;
    logic        StallM, s_StallM;
    logic        mem_req, s_mem_req, mem_we, s_mem_we;
    logic [31:0] mem_addr, s_mem_addr, mem_wdata, s_mem_wdata;
    logic [3:0]  mem_be, s_mem_be;
    logic [31:0] mem_rdata;
    logic        mem_ack;
    logic [15:0] hit_count, miss_count;
    logic [1:0]  s_hit_count, s_miss_count;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model: backing memory plus which tag each set currently holds.
    logic [31:0] bmem [int];
    bit          m_valid [16];
    logic [25:0] m_tag   [16];
    int          m_hits, m_misses;

    always #5 clk = ~clk;

    data_cache #(.SETS(16), .CNT_WIDTH(16)) dut (
        .clk(clk), .rst(rst), .MemReadM(MemReadM), .MemWriteM(MemWriteM),
        .LdSrcM(LdSrcM), .StSrcM(StSrcM), .ALUResultM(ALUResultM), .WriteDataM(WriteDataM),
        .ReadDataM(ReadDataM), .StallM(StallM), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_rdata(mem_rdata),
        .mem_ack(mem_ack), .hit_count(hit_count), .miss_count(miss_count)
    );

    data_cache #(.SETS(16), .CNT_WIDTH(2)) dut_s (
        .clk(clk), .rst(rst), .MemReadM(MemReadM), .MemWriteM(MemWriteM),
        .LdSrcM(LdSrcM), .StSrcM(StSrcM), .ALUResultM(ALUResultM), .WriteDataM(WriteDataM),
        .ReadDataM(s_ReadDataM), .StallM(s_StallM), .mem_req(s_mem_req), .mem_we(s_mem_we),
        .mem_addr(s_mem_addr), .mem_wdata(s_mem_wdata), .mem_be(s_mem_be),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack), .hit_count(s_hit_count),
        .miss_count(s_miss_count)
    );

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        int w = int'(a >> 2);
        if (bmem.exists(w)) return bmem[w];
        return {a[31:2], 2'b00} ^ 32'h5A5A_1234;
    endfunction

    task automatic mem_wr(input logic [31:0] a, input logic [3:0] be, input logic [31:0] d);
        logic [31:0] w = mem_rd(a);
        for (int b = 0; b < 4; b++) if (be[b]) w[8*b +: 8] = d[8*b +: 8];
        bmem[int'(a >> 2)] = w;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m_valid[i] = 0;
        m_hits = 0;
        m_misses = 0;
    endtask

    task automatic idle_inputs();
        MemReadM = 0; MemWriteM = 0; LdSrcM = 0; StSrcM = 0;
        ALUResultM = '0; WriteDataM = '0;
    endtask

    // Called at posedge+1; returns at posedge+1 with the M-stage inputs idle again.
    task automatic do_op(input bit st, input bit byt, input logic [31:0] addr,
                         input logic [31:0] wd, input int lat,
                         output logic [31:0] obs_rd, output bit obs_stall);
        int          idx;
        logic [25:0] tg;
        bit          hit;
        logic [1:0]  off;
        logic [31:0] word, exp_rd, exp_wd;
        logic [3:0]  exp_be;
        int          exp_h2, exp_m2;
        off = addr[1:0];
        idx = int'(addr[5:2]);
        tg  = addr[31:6];
        hit = m_valid[idx] && (m_tag[idx] == tg);
        exp_be = byt ? (4'b0001 << off) : 4'b1111;
        exp_wd = byt ? ({24'b0, wd[7:0]} << (8 * off)) : wd;
        MemWriteM = st; MemReadM = !st; LdSrcM = byt; StSrcM = byt;
        ALUResultM = addr; WriteDataM = wd;
        @(negedge clk);
        obs_stall = StallM;
        if (!st && hit) begin
            word = mem_rd(addr);
            exp_rd = byt ? ((word >> (8 * off)) & 32'hFF) : word;
            obs_rd = ReadDataM;
            n_assert++;
            if (StallM !== 1'b0) begin
                n_fail++; $display("FAIL hit_stall addr=%h got %b want 0", addr, StallM);
            end
            n_assert++;
            if (ReadDataM !== exp_rd) begin
                n_fail++; $display("FAIL hit_data addr=%h got %h want %h", addr, ReadDataM, exp_rd);
            end
            @(posedge clk); #1;
            m_hits++;
        end else begin
            n_assert++;
            if (StallM !== 1'b1) begin
                n_fail++; $display("FAIL detect_stall addr=%h got %b want 1", addr, StallM);
            end
            @(posedge clk); #1;
            if (!st) m_misses++;
            for (int i = 0; i < lat; i++) begin
                @(negedge clk);
                n_assert++;
                if (mem_req !== 1'b1 || StallM !== 1'b1) begin
                    n_fail++;
                    $display("FAIL wait_req addr=%h got req=%b stall=%b want 1/1", addr, mem_req, StallM);
                end
                @(posedge clk); #1;
            end
            mem_ack = 1'b1;
            mem_rdata = st ? 32'hBAD0_BAD0 : mem_rd(addr);
            @(negedge clk);
            n_assert++;
            if (mem_req !== 1'b1 || mem_we !== st || mem_addr !== {addr[31:2], 2'b00}) begin
                n_fail++;
                $display("FAIL req_fields addr=%h got req=%b we=%b maddr=%h want 1/%b/%h",
                         addr, mem_req, mem_we, mem_addr, st, {addr[31:2], 2'b00});
            end
            if (st) begin
                n_assert++;
                if (mem_be !== exp_be || mem_wdata !== exp_wd) begin
                    n_fail++;
                    $display("FAIL store_lane addr=%h got be=%b wdata=%h want %b/%h",
                             addr, mem_be, mem_wdata, exp_be, exp_wd);
                end
            end
            @(posedge clk); #1;
            mem_ack = 1'b0;
            mem_rdata = $urandom;
            if (st) begin
                mem_wr(addr, exp_be, exp_wd);
            end else begin
                m_valid[idx] = 1;
                m_tag[idx]   = tg;
            end
            @(negedge clk);
            word = mem_rd(addr);
            exp_rd = st ? 32'h0 : (byt ? ((word >> (8 * off)) & 32'hFF) : word);
            obs_rd = ReadDataM;
            n_assert++;
            if (StallM !== 1'b0 || mem_req !== 1'b0) begin
                n_fail++;
                $display("FAIL done_cycle addr=%h got stall=%b req=%b want 0/0", addr, StallM, mem_req);
            end
            n_assert++;
            if (ReadDataM !== exp_rd) begin
                n_fail++; $display("FAIL done_data addr=%h got %h want %h", addr, ReadDataM, exp_rd);
            end
            @(posedge clk); #1;
        end
        idle_inputs();
        exp_h2 = (m_hits > 3) ? 3 : m_hits;
        exp_m2 = (m_misses > 3) ? 3 : m_misses;
        n_assert++;
        if (hit_count !== 16'(m_hits) || miss_count !== 16'(m_misses)) begin
            n_fail++;
            $display("FAIL counters got hit=%0d miss=%0d want %0d/%0d",
                     hit_count, miss_count, m_hits, m_misses);
        end
        n_assert++;
        if (s_hit_count !== 2'(exp_h2) || s_miss_count !== 2'(exp_m2)) begin
            n_fail++;
            $display("FAIL sat_counters got hit=%0d miss=%0d want %0d/%0d",
                     s_hit_count, s_miss_count, exp_h2, exp_m2);
        end
    endtask

    task automatic apply_reset();
        rst = 1'b0;
        idle_inputs();
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        rst = 1'b0;
        idle_inputs();
        MemWriteM = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        n_assert++;
        if (StallM !== 1'b0) begin
            n_fail++; $display("FAIL reset_stall got %b want 0", StallM);
        end
        @(posedge clk); #1;
        idle_inputs();
        rst = 1'b1;
        model_reset();
        @(negedge clk);
        n_assert++;
        if (mem_req !== 0 || mem_we !== 0 || mem_addr !== 0 || mem_wdata !== 0 || mem_be !== 0 ||
            hit_count !== 0 || miss_count !== 0 || StallM !== 0) begin
            n_fail++;
            $display("FAIL reset_state got req=%b we=%b addr=%h wd=%h be=%b hc=%0d mc=%0d st=%b want all 0",
                     mem_req, mem_we, mem_addr, mem_wdata, mem_be, hit_count, miss_count, StallM);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_load_miss_hit();
        logic [31:0] rd;
        bit          stl;
        bmem[32'h100 >> 2] = 32'hDEAD_BEEF;
        do_op(0, 0, 32'h100, 0, 3, rd, stl);
        n_assert++;
        if (rd !== 32'hDEAD_BEEF || stl !== 1'b1) begin
            n_fail++; $display("FAIL lw_miss_100 got %h stall=%b want deadbeef/1", rd, stl);
        end
        do_op(0, 0, 32'h100, 0, 0, rd, stl);
        n_assert++;
        if (stl !== 1'b0 || hit_count !== 16'd1 || miss_count !== 16'd1) begin
            n_fail++;
            $display("FAIL lw_hit_100 got stall=%b hc=%0d mc=%0d want 0/1/1", stl, hit_count, miss_count);
        end
    endtask

    task automatic test_conflict();
        logic [31:0] rd;
        bit          stl;
        do_op(0, 0, 32'h140, 0, 1, rd, stl);
        do_op(0, 0, 32'h100, 0, 0, rd, stl);
        n_assert++;
        if (stl !== 1'b1 || miss_count !== 16'd3 || rd !== 32'hDEAD_BEEF) begin
            n_fail++;
            $display("FAIL conflict got stall=%b mc=%0d rd=%h want 1/3/deadbeef", stl, miss_count, rd);
        end
    endtask

    task automatic test_byte_store();
        logic [31:0] rd;
        bit          stl;
        do_op(1, 1, 32'h101, 32'h0000_00AA, 0, rd, stl);
        do_op(0, 1, 32'h101, 0, 0, rd, stl);
        n_assert++;
        if (rd !== 32'h0000_00AA || stl !== 1'b0) begin
            n_fail++; $display("FAIL lbu_101 got %h stall=%b want 000000aa/0", rd, stl);
        end
        do_op(0, 0, 32'h100, 0, 0, rd, stl);
        n_assert++;
        if (rd !== 32'hDEAD_AAEF || stl !== 1'b0) begin
            n_fail++; $display("FAIL lw_after_sb got %h stall=%b want deadaaef/0", rd, stl);
        end
    endtask

    task automatic test_store_miss();
        logic [31:0] rd;
        bit          stl;
        do_op(1, 0, 32'h200, 32'h1357_9BDF, 2, rd, stl);
        do_op(0, 0, 32'h200, 0, 1, rd, stl);
        n_assert++;
        if (stl !== 1'b1 || rd !== 32'h1357_9BDF) begin
            n_fail++; $display("FAIL sw_no_alloc got stall=%b rd=%h want 1/13579bdf", stl, rd);
        end
    endtask

    task automatic test_reset_during_miss();
        logic [31:0] rd;
        bit          stl;
        MemReadM = 1'b1; ALUResultM = 32'h300;
        @(posedge clk); #1;
        @(negedge clk);
        n_assert++;
        if (mem_req !== 1'b1) begin
            n_fail++; $display("FAIL rdmiss_req got %b want 1", mem_req);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        idle_inputs();
        @(posedge clk); #1;
        n_assert++;
        if (mem_req !== 1'b0 || StallM !== 1'b0 || miss_count !== 0) begin
            n_fail++;
            $display("FAIL reset_abandon got req=%b stall=%b mc=%0d want 0/0/0", mem_req, StallM, miss_count);
        end
        rst = 1'b1;
        model_reset();
        @(posedge clk); #1;
        mem_ack = 1'b1; mem_rdata = 32'hFFFF_0000;
        @(negedge clk);
        n_assert++;
        if (mem_req !== 1'b0 || StallM !== 1'b0) begin
            n_fail++; $display("FAIL late_ack got req=%b stall=%b want 0/0", mem_req, StallM);
        end
        @(posedge clk); #1;
        mem_ack = 1'b0;
        @(negedge clk);
        n_assert++;
        if (mem_req !== 1'b0 || StallM !== 1'b0) begin
            n_fail++; $display("FAIL after_late_ack got req=%b stall=%b want 0/0", mem_req, StallM);
        end
        @(posedge clk); #1;
        do_op(0, 0, 32'h100, 0, 0, rd, stl);
        n_assert++;
        if (stl !== 1'b1) begin
            n_fail++; $display("FAIL post_reset_miss got stall=%b want 1", stl);
        end
    endtask

    task automatic test_saturation();
        logic [31:0] rd;
        bit          stl;
        apply_reset();
        do_op(0, 0, 32'h100, 0, 0, rd, stl);
        for (int i = 0; i < 5; i++) do_op(0, 0, 32'h100, 0, 0, rd, stl);
        n_assert++;
        if (s_hit_count !== 2'd3 || hit_count !== 16'd5) begin
            n_fail++; $display("FAIL hit_saturate got sat=%0d full=%0d want 3/5", s_hit_count, hit_count);
        end
    endtask

    task automatic test_random();
        logic [31:0] rd, a;
        bit          stl;
        for (int n = 0; n < 120; n++) begin
            a = (32'($urandom_range(0, 3)) << 6) | (32'($urandom_range(0, 15)) << 2) |
                32'($urandom_range(0, 3));
            do_op(($urandom_range(0, 9) < 4), $urandom_range(0, 1), a, $urandom,
                  $urandom_range(0, 3), rd, stl);
        end
    endtask

    initial begin
        mem_ack = 1'b0;
        mem_rdata = '0;
        rst = 1'b0;
        idle_inputs();
        @(posedge clk); #1;
        test_reset();
        test_load_miss_hit();
        test_conflict();
        test_byte_store();
        test_store_miss();
        test_reset_during_miss();
        test_saturation();
        apply_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/data_cache.md
# data_cache

Direct-mapped, write-through L1 data cache between the memory-stage pipeline register and the backing data memory. It serves loads from the M stage in the same cycle on a hit. Load misses and all stores go to a multi-cycle backing memory over a req/ack handshake, and `StallM` freezes the pipeline while they complete. It also keeps saturating hit and miss counters for performance reporting.

## Interface
Parameters:
- `SETS`, 16 — number of one-word lines; power of two, ≥ 2; `IDX_W = log2(SETS)`.
- `CNT_WIDTH`, 16 — width of the hit and miss counters.

Ports:
- `clk`  in  1  — single clock; all state changes on its rising edge.
- `rst`  in  1  — synchronous, active-low reset.
- `MemReadM`  in  1  — load present in the M stage.
- `MemWriteM`  in  1  — store present in the M stage; has priority over `MemReadM`.
- `LdSrcM`  in  1  — 1 = byte load (zero-extended, lbu); 0 = word load.
- `StSrcM`  in  1  — 1 = byte store; 0 = word store.
- `ALUResultM`  in  32  — byte address.
- `WriteDataM`  in  32  — store data; the byte store uses `[7:0]`.
- `ReadDataM`  out  32  — load result.
- `StallM`  out  1  — holds the F–M stages.
- `mem_req`  out  1  — backing-memory request.
- `mem_we`  out  1  — 1 = write request.
- `mem_addr`  out  32  — word-aligned address (`[1:0]` = 0).
- `mem_wdata`  out  32  — write data, byte placed in its lane.
- `mem_be`  out  4  — byte enables.
- `mem_rdata`  in  32  — fill data, valid when `mem_ack` = 1.
- `mem_ack`  in  1  — one-cycle completion pulse.
- `hit_count`  out  `CNT_WIDTH`  — load hits.
- `miss_count`  out  `CNT_WIDTH`  — load misses.

## Operation
Address split:
- index = `ALUResultM[IDX_W+1:2]`
- tag = `ALUResultM[31:IDX_W+2]`
- hit = `valid[index]` && tag match.

FSM states: IDLE, RD_MISS, WR_THRU, DONE.
- **IDLE:**
  - Store: capture the request and go to WR_THRU.
  - Load miss: capture the request and go to RD_MISS.
  - Load hit: stay in IDLE, increment `hit_count`.
  - No request: stay in IDLE.
- **RD_MISS:** hold `mem_req`=1, `mem_we`=0. On `mem_ack`, write `mem_rdata` into the line, set valid, write the tag, go to DONE. Entry into RD_MISS increments `miss_count`.
- **WR_THRU:** hold `mem_req`=1, `mem_we`=1. On `mem_ack`:
  - Store hit: update only the enabled bytes of the line.
  - Store miss: no allocate.
  - Go to DONE.
- **DONE:** release the stall for exactly one cycle, then go to IDLE unconditionally. The M-stage inputs are not re-evaluated in DONE.

Request outputs:
- `mem_addr`, `mem_wdata`, `mem_be` and `mem_we` are registered at capture and held stable until ack.
- Word store: `mem_be`=4'b1111, `mem_wdata`=`WriteDataM`.
- Byte store: `mem_be` = 1 << `addr[1:0]`; `mem_wdata` = `WriteDataM[7:0]` shifted to lane `addr[1:0]`.

Load data and stall:
- `ReadDataM` comes from the line at the current index.
  - Word load: the whole word; `addr[1:0]` is ignored.
  - Byte load: the byte at `addr[1:0]`, zero-extended.
  - When no load is present, `ReadDataM` = 0.
- `StallM` = (state ∈ {RD_MISS, WR_THRU}) || (state = IDLE && (`MemWriteM` || (`MemReadM` && !hit))).

Counters saturate at all-ones. Stores are not counted.

Edge cases:
- A `mem_ack` in IDLE or DONE is ignored.
- `MemReadM` and `MemWriteM` both high is treated as a store.

## Timing
- Load hit: zero extra cycles; `ReadDataM` is combinational from the lookup and `StallM`=0.
- Load miss:
  - `StallM`=1 combinationally in the detect cycle.
  - `mem_req`=1 from the next edge.
  - Ack arrives in cycle k; DONE is cycle k+1 with `StallM`=0 and `ReadDataM` = filled data.
- Store: same sequence. The minimum occupancy is 3 cycles (detect, ack, DONE) when ack comes in the first request cycle.
- `mem_req` falls on the edge after ack.
- Reset (`rst`=0 at an edge):
  - state ← IDLE, all valid bits ← 0, counters ← 0, `mem_req`/`mem_we` ← 0, `mem_addr`/`mem_wdata` ← 0, `mem_be` ← 0.
  - While `rst`=0, `StallM`=0.
  - Reset during RD_MISS or WR_THRU abandons the transaction; a late ack is ignored.

## Structure
- Package `cache_pkg`:
  - state enum `cache_state_t`.
  - `BE_WORD` = 4'b1111.
  - Address-field localparam helpers.
- Sub-module `cache_line_array`:
  - valid/tag/data storage with combinational read and byte-enable synchronous write.
  - Clearing valid on reset.
- The top level holds the FSM, request registers, lane/extend logic and counters.

## Test plan
All scenarios use `SETS`=16.
- Reset, then `lw` 0x100 with `mem_rdata`=0xDEADBEEF acked 3 cycles after `mem_req` → `mem_addr`=0x100; DONE cycle shows `ReadDataM`=0xDEADBEEF, `StallM`=0; `miss_count`=1. Repeat `lw` 0x100 → no stall, `hit_count`=1.
- Conflict: `lw` 0x140 (index 0, new tag) misses and evicts the line; next `lw` 0x100 misses again → `miss_count`=3.
- After `lw` 0x100 (0xDEADBEEF), `sb` 0x101 with `WriteDataM`=0xAA → `mem_be`=4'b0010, `mem_wdata`=0x0000AA00. Then `lbu` 0x101 → 0x000000AA; `lw` 0x100 → 0xDEADAAEF, both hits.
- `sw` 0x200 (miss) → write-through with `mem_be`=4'b1111, no allocate; next `lw` 0x200 misses.
- Drop `rst` during RD_MISS → `mem_req`=0 on the next edge; ack 2 cycles later is ignored; `lw` 0x100 misses.
- `CNT_WIDTH`=2, five hits → `hit_count` saturates at 3.
